// File: rtl/optimsoc_trace_pkg.sv
// Shared types and constants for the trace event collector: event encoding
// carried through the per-core FIFOs and the magic NOP that marks an event.
package optimsoc_trace_pkg;

  localparam logic [15:0] NOP_PREFIX = 16'h1500;
  localparam logic [15:0] K_EXIT     = 16'd1;
  localparam logic [15:0] K_REPORT   = 16'd2;
  localparam logic [15:0] K_PUTC     = 16'd4;

  typedef enum logic [1:0] {
    EV_EXIT   = 2'd0,
    EV_REPORT = 2'd1,
    EV_PUTC   = 2'd2
  } event_type_e;

  typedef struct packed {
    event_type_e etype;
    logic [31:0] data;
  } trace_event_t;

endpackage

// File: rtl/trace_event_fifo.sv
// Per-core event FIFO; pointers carry an extra wrap bit so full/empty need no counter.
module trace_event_fifo
  import optimsoc_trace_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = trace_event_t
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  T     wr_data,
  input  logic rd_en,
  output T     rd_data,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/trace_event_collector.sv
// Collects EXIT/REPORT/PUTC trace events from NUM_CORES cores, buffers them per
// core and serialises them through a round-robin arbiter into one output register.
module trace_event_collector
  import optimsoc_trace_pkg::*;
#(
  parameter int NUM_CORES  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 0,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CORES-1:0]       trace_valid,
  input  logic [NUM_CORES-1:0][31:0] trace_insn,
  input  logic [NUM_CORES-1:0]       trace_wben,
  input  logic [NUM_CORES-1:0][4:0]  trace_wbreg,
  input  logic [NUM_CORES-1:0][31:0] trace_wbdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_core,
  output logic [1:0]                 out_type,
  output logic [31:0]                out_data,
  output logic [NUM_CORES-1:0]       core_exited,
  output logic                       terminate_all,
  output logic                       timeout_hit,
  output logic [15:0]                drop_count
);

  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input int unsigned n);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(n);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [31:0]          r3 [NUM_CORES];
  trace_event_t         ev_p0 [NUM_CORES];
  trace_event_t         fifo_q [NUM_CORES];
  logic [NUM_CORES-1:0] ev_hit_p0, exit_hit_p0, fifo_wr, fifo_rd, fifo_empty, fifo_full;
  int unsigned          drop_n_p0;
  logic [CW-1:0]        rr_ptr, grant;
  logic                 grant_vld, load;
  trace_event_t         grant_ev;
  logic [31:0]          tmo_cnt;

  // Stage p0: decode the retired instruction; payload is r3 before this cycle's writeback
  always_comb begin
    drop_n_p0 = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      ev_p0[i]       = '{etype: EV_REPORT, data: r3[i]};
      ev_hit_p0[i]   = 1'b0;
      if (trace_insn[i][31:16] == NOP_PREFIX) begin
        case (trace_insn[i][15:0])
          K_EXIT:   begin ev_p0[i].etype = EV_EXIT;   ev_hit_p0[i] = 1'b1; end
          K_REPORT: begin ev_p0[i].etype = EV_REPORT; ev_hit_p0[i] = 1'b1; end
          K_PUTC: begin
            ev_p0[i].etype = EV_PUTC;
            ev_p0[i].data  = {24'h0, r3[i][7:0]};
            ev_hit_p0[i]   = 1'b1;
          end
          default: ;
        endcase
      end
      ev_hit_p0[i]   = ev_hit_p0[i] && trace_valid[i] && !core_exited[i] && !terminate_all;
      exit_hit_p0[i] = ev_hit_p0[i] && (ev_p0[i].etype == EV_EXIT);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      fifo_wr[i]     = ev_hit_p0[i] && (!fifo_full[i] || fifo_rd[i]);
      if (ev_hit_p0[i] && !fifo_wr[i]) drop_n_p0 = drop_n_p0 + 1;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_fifo
    trace_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (trace_event_t)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr[g]),
      .wr_data (ev_p0[g]),
      .rd_en   (fifo_rd[g]),
      .rd_data (fifo_q[g]),
      .empty   (fifo_empty[g]),
      .full    (fifo_full[g])
    );
  end

  // Stage p1: round-robin pick among non-empty FIFOs, starting at rr_ptr
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    grant_ev  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CORES;
      if (!grant_vld && !fifo_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = CW'(idx);
        grant_ev  = fifo_q[idx];
      end
    end
    load = grant_vld && (!out_valid || out_ready);
    for (int i = 0; i < NUM_CORES; i++) fifo_rd[i] = load && (grant == CW'(i));
  end

  // Stage p2: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_core  <= '0;
      out_type  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_core  <= grant;
      out_type  <= grant_ev.etype;
      out_data  <= grant_ev.data;
      rr_ptr    <= (grant == CW'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_exited   <= '0;
      terminate_all <= 1'b0;
      timeout_hit   <= 1'b0;
      drop_count    <= '0;
      tmo_cnt       <= '0;
      for (int i = 0; i < NUM_CORES; i++) r3[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (trace_valid[i] && trace_wben[i] && trace_wbreg[i] == 5'd3) r3[i] <= trace_wbdata[i];
      end
      core_exited <= core_exited | exit_hit_p0;
      drop_count  <= sat_add16(drop_count, drop_n_p0);
      if (&core_exited && &fifo_empty && !out_valid) terminate_all <= 1'b1;
      if (TIMEOUT > 0 && |core_exited && !timeout_hit) begin
        if (tmo_cnt == 32'(TIMEOUT - 1)) begin
          timeout_hit   <= 1'b1;
          terminate_all <= 1'b1;
        end
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_event_collector.sv
// Directed bench: a 4-core instance (no timeout) and a 2-core instance (TIMEOUT=100).
module tb_trace_event_collector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: 4 cores, depth 4, no timeout
  logic             a_rst, a_ready, a_out_valid, a_term, a_tmo;
  logic [3:0]       a_valid, a_wben, a_exited;
  logic [3:0][31:0] a_insn, a_wbdata;
  logic [3:0][4:0]  a_wbreg;
  logic [1:0]       a_out_core, a_out_type;
  logic [31:0]      a_out_data;
  logic [15:0]      a_drop;

  // Instance B: 2 cores, depth 4, TIMEOUT=100
  logic             b_rst, b_ready, b_out_valid, b_term, b_tmo;
  logic [1:0]       b_valid, b_wben, b_exited;
  logic [1:0][31:0] b_insn, b_wbdata;
  logic [1:0][4:0]  b_wbreg;
  logic [0:0]       b_out_core;
  logic [1:0]       b_out_type;
  logic [31:0]      b_out_data;
  logic [15:0]      b_drop;

  trace_event_collector #(.NUM_CORES(4), .FIFO_DEPTH(4), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(a_rst), .trace_valid(a_valid), .trace_insn(a_insn),
    .trace_wben(a_wben), .trace_wbreg(a_wbreg), .trace_wbdata(a_wbdata),
    .out_valid(a_out_valid), .out_ready(a_ready), .out_core(a_out_core),
    .out_type(a_out_type), .out_data(a_out_data), .core_exited(a_exited),
    .terminate_all(a_term), .timeout_hit(a_tmo), .drop_count(a_drop));

  trace_event_collector #(.NUM_CORES(2), .FIFO_DEPTH(4), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(b_rst), .trace_valid(b_valid), .trace_insn(b_insn),
    .trace_wben(b_wben), .trace_wbreg(b_wbreg), .trace_wbdata(b_wbdata),
    .out_valid(b_out_valid), .out_ready(b_ready), .out_core(b_out_core),
    .out_type(b_out_type), .out_data(b_out_data), .core_exited(b_exited),
    .terminate_all(b_term), .timeout_hit(b_tmo), .drop_count(b_drop));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_valid = '0; a_wben = '0; a_insn = '0; a_wbreg = '0; a_wbdata = '0;
  endtask

  task automatic b_idle();
    b_valid = '0; b_wben = '0; b_insn = '0; b_wbreg = '0; b_wbdata = '0;
  endtask

  task automatic a_drive(input int c, input logic [31:0] insn, input logic wb, input logic [31:0] wbd);
    a_valid[c] = 1'b1; a_insn[c] = insn; a_wben[c] = wb; a_wbreg[c] = 5'd3; a_wbdata[c] = wbd;
  endtask

  task automatic b_drive(input int c, input logic [31:0] insn, input logic wb, input logic [31:0] wbd);
    b_valid[c] = 1'b1; b_insn[c] = insn; b_wben[c] = wb; b_wbreg[c] = 5'd3; b_wbdata[c] = wbd;
  endtask

  initial begin
    a_idle(); b_idle();
    a_rst = 1'b1; b_rst = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0;

    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_drop", a_drop, 0);
    check("rst_a_exited", a_exited, 0);
    check("rst_a_term", a_term, 0);
    check("rst_b_term", b_term, 0);
    check("rst_b_tmo", b_tmo, 0);

    // Single PUTC with 2-cycle latency
    a_drive(0, 32'h0000_0013, 1'b1, 32'h41); step(); a_idle();
    a_drive(0, 32'h1500_0004, 1'b0, 32'h0);  step(); a_idle();
    check("putc_lat1_valid", a_out_valid, 0);
    step();
    check("putc_valid", a_out_valid, 1);
    check("putc_core", a_out_core, 0);
    check("putc_type", a_out_type, 2);
    check("putc_data", a_out_data, 32'h41);

    // REPORT payload uses r3 before the same-cycle writeback
    a_drive(0, 32'h1500_0002, 1'b1, 32'h99); step(); a_idle();
    check("rep_gap_valid", a_out_valid, 0);
    step();
    check("rep_old_type", a_out_type, 1);
    check("rep_old_data", a_out_data, 32'h41);
    a_drive(0, 32'h1500_0002, 1'b0, 32'h0); step(); a_idle();
    step();
    check("rep_new_data", a_out_data, 32'h99);
    a_drive(0, 32'h1500_0003, 1'b0, 32'h0); step(); a_idle();
    step();
    check("k3_ignored", a_out_valid, 0);

    // Round robin: all cores PUTC in one cycle
    a_rst = 1'b1; step(); a_rst = 1'b0;
    check("rst2_data", a_out_data, 0);
    check("rst2_type", a_out_type, 0);
    for (int i = 0; i < 4; i++) a_drive(i, 32'h0000_0013, 1'b1, 32'h30 + i);
    step(); a_idle();
    for (int i = 0; i < 4; i++) a_drive(i, 32'h1500_0004, 1'b0, 32'h0);
    step(); a_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_core", a_out_core, i);
      check("rr_data", a_out_data, 32'h30 + i);
    end
    step();
    check("rr_done", a_out_valid, 0);

    // Backpressure: 6 events, 4 buffered, 1 held, 1 dropped
    a_ready = 1'b0;
    a_drive(0, 32'h0000_0013, 1'b1, 32'h100); step(); a_idle();
    for (int j = 0; j < 6; j++) begin
      a_drive(0, 32'h1500_0002, 1'b1, 32'h200 + j); step(); a_idle();
      if (j == 0) check("bp_first_valid", a_out_valid, 0);
      else begin
        check("bp_hold_valid", a_out_valid, 1);
        check("bp_hold_data", a_out_data, 32'h100);
        check("bp_hold_type", a_out_type, 1);
      end
    end
    check("bp_drop", a_drop, 1);
    step(); step();
    check("bp_stable_data", a_out_data, 32'h100);
    check("bp_stable_core", a_out_core, 0);
    a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_drain_data", a_out_data, 32'h200 + k);
    end
    step();
    check("bp_drain_done", a_out_valid, 0);
    check("bp_drop_final", a_drop, 1);

    // Reset while events are pending
    a_ready = 1'b0;
    for (int i = 1; i < 4; i++) a_drive(i, 32'h1500_0004, 1'b0, 32'h0);
    step(); a_idle();
    step();
    check("pend_valid", a_out_valid, 1);
    a_rst = 1'b1; step(); a_rst = 1'b0;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_core", a_out_core, 0);
    check("midrst_data", a_out_data, 0);
    check("midrst_drop", a_drop, 0);
    a_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("midrst_no_stale", a_out_valid, 0);
    end

    // Two-core exit sequence
    b_drive(1, 32'h0000_0013, 1'b1, 32'h55); step(); b_idle();
    b_drive(0, 32'h1500_0001, 1'b0, 32'h0);  step(); b_idle();
    check("ex0_exited", b_exited, 2'b01);
    step();
    check("ex0_valid", b_out_valid, 1);
    check("ex0_type", b_out_type, 0);
    check("ex0_data", b_out_data, 0);
    b_drive(0, 32'h1500_0004, 1'b0, 32'h0); step(); b_idle();
    for (int k = 0; k < 7; k++) begin
      step();
      check("ex_gap_term", b_term, 0);
    end
    check("ex_ignored_valid", b_out_valid, 0);
    check("ex_ignored_drop", b_drop, 0);
    b_drive(1, 32'h1500_0001, 1'b0, 32'h0); step(); b_idle();
    check("ex1_exited", b_exited, 2'b11);
    check("ex1_term_c0", b_term, 0);
    step();
    check("ex1_core", b_out_core, 1);
    check("ex1_data", b_out_data, 32'h55);
    check("ex1_term_c1", b_term, 0);
    step();
    check("ex1_term_c2", b_term, 0);
    step();
    check("ex1_term_set", b_term, 1);

    // Timeout with only core 0 exiting
    b_rst = 1'b1; step(); b_rst = 1'b0;
    check("tmo_rst_term", b_term, 0);
    check("tmo_rst_exited", b_exited, 0);
    b_drive(0, 32'h1500_0001, 1'b0, 32'h0); step(); b_idle();
    check("tmo_exited", b_exited, 2'b01);
    for (int k = 1; k < 100; k++) step();
    check("tmo_99_hit", b_tmo, 0);
    check("tmo_99_term", b_term, 0);
    step();
    check("tmo_100_hit", b_tmo, 1);
    check("tmo_100_term", b_term, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trace_event_collector.md
TRACE_EVENT_COLLECTOR -- requirements
Module: trace_event_collector

Interface
REQ-001 SHALL have parameter NUM_CORES, default 1: number of traced cores, 1..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: per-core event FIFO entries, a power of two and at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 0: cycles from the first exit to a forced terminate_all; 0 disables it.
REQ-004 Ports, in order:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- trace_valid  in  NUM_CORES  instruction retired.
- trace_insn  in  NUM_CORES x 32  retired instruction.
- trace_wben  in  NUM_CORES  register writeback enable.
- trace_wbreg  in  NUM_CORES x 5  writeback register index.
- trace_wbdata  in  NUM_CORES x 32  writeback data.
- out_valid  out  1  event available.
- out_ready  in  1  consumer accepts.
- out_core  out  max(1,clog2(NUM_CORES))  source core.
- out_type  out  2  0=EXIT, 1=REPORT, 2=PUTC.
- out_data  out  32  event payload.
- core_exited  out  NUM_CORES  sticky, per core.
- terminate_all  out  1  sticky.
- timeout_hit  out  1  sticky.
- drop_count  out  16  saturating count of dropped events.

Function
REQ-005 SHALL keep a per-core shadow r3, loaded with trace_wbdata when trace_valid, trace_wben and trace_wbreg==3.
REQ-006 SHALL detect an event when trace_valid and trace_insn[31:16]==16'h1500; K = trace_insn[15:0].
REQ-007 Event type by K: K=1 EXIT, K=2 REPORT, K=4 PUTC; any other K is ignored.
REQ-008 Payload SHALL be the shadow r3 value before any same-cycle update; for PUTC it SHALL be {24'h0, r3[7:0]}.
REQ-009 An event SHALL be written into its core's FIFO at the clock edge ending its trace_valid cycle.
REQ-010 An event arriving at a full FIFO SHALL be dropped and drop_count incremented, saturating at 16'hFFFF.
REQ-011 Events from a core whose core_exited bit is set SHALL be ignored and SHALL NOT be counted as drops.
REQ-012 core_exited[i] SHALL set on the edge that enqueues core i's EXIT; an EXIT dropped on a full FIFO still sets it.
REQ-013 The output register SHALL load from a round-robin arbiter over non-empty FIFOs, starting at the core after the last grant.
REQ-014 First-event latency: out_valid SHALL rise 2 cycles after the event's trace_valid cycle when the output register is idle.
REQ-015 While out_valid && !out_ready, out_core, out_type and out_data SHALL stay stable.
REQ-016 When out_valid && out_ready, the next event SHALL load in the same edge (back-to-back, one event per cycle).
REQ-017 terminate_all SHALL set once all core_exited bits are 1, all FIFOs are empty and out_valid is 0.
REQ-018 With TIMEOUT>0, a counter SHALL start at the first core_exited set. At TIMEOUT cycles it sets timeout_hit and terminate_all, whatever the other cores' state.
REQ-019 After terminate_all, event capture SHALL stop; pending FIFO contents SHALL still drain.
REQ-020 A simultaneous FIFO write and read on the same core SHALL both succeed, full or not.

Reset
REQ-021 On rst, all of the following SHALL clear in the same edge: out_valid, out_core, out_type, out_data, core_exited, terminate_all, timeout_hit, drop_count, the shadow r3 registers, FIFO pointers, the arbiter pointer (core 0) and the timeout counter.
REQ-022 Reset mid-transfer SHALL discard all pending events; no event from before reset SHALL appear afterwards.

Structure
REQ-023 Shared package optimsoc_trace_pkg SHALL hold:
- the event type enum;
- the NOP constants 16'h1500 and K=1/2/4;
- the event struct {type, data}.
REQ-024 The per-core FIFO SHALL be a sub-module, trace_event_fifo (parameters DEPTH and the struct type), instantiated NUM_CORES times.

Verification
REQ-025 NUM_CORES=1: write r3=0x41, then retire 0x15000004 -> one PUTC, data 0x00000041, out_valid 2 cycles later.
REQ-026 NUM_CORES=4, out_ready=1: all cores emit PUTC in the same cycle -> out_core order 0,1,2,3 on consecutive cycles.
REQ-027 out_ready=0, FIFO_DEPTH=4: 6 events from core 0 -> 4 buffered, 1 in the output register, drop_count=1; output stable throughout.
REQ-028 NUM_CORES=2: core 0 exits with r3=0; core 1 exits 10 cycles later -> terminate_all rises only after both EXIT events are consumed.
REQ-029 NUM_CORES=2, TIMEOUT=100: only core 0 exits -> timeout_hit and terminate_all rise exactly 100 cycles after core_exited[0].
REQ-030 Assert rst while 3 events are pending -> all outputs 0 next cycle; no stale event appears afterwards.
